// File: rtl/switch_allocator.sv
// rtl/switch_allocator.sv - per-cycle round-robin switch allocator with wormhole output locks
module switch_allocator #(
    parameter int NUM_PORTS = 7,
    parameter int PORT_W    = $clog2(NUM_PORTS),
    parameter bit LOCK_EN   = 1'b1
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NUM_PORTS-1:0]             req_valid_i,
    input  logic [NUM_PORTS-1:0][PORT_W-1:0] req_dir_i,
    input  logic [NUM_PORTS-1:0]             req_tail_i,
    input  logic [NUM_PORTS-1:0]             out_ready_i,
    output logic [NUM_PORTS-1:0]             grant_o,
    output logic [NUM_PORTS-1:0][PORT_W-1:0] xbar_sel_o,
    output logic [NUM_PORTS-1:0]             xbar_valid_o,
    output logic [NUM_PORTS-1:0]             out_locked_o
);

    logic [NUM_PORTS-1:0]                lock_vld_q, lock_vld_d;
    logic [NUM_PORTS-1:0][PORT_W-1:0]    lock_own_q, lock_own_d;
    logic [NUM_PORTS-1:0][PORT_W-1:0]    rr_ptr_q, rr_ptr_d;

    // cand[o][i]: input i is asking for output o this cycle
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] cand;
    logic [NUM_PORTS-1:0]                win_vld;
    logic [NUM_PORTS-1:0][PORT_W-1:0]    win_idx;
    logic [NUM_PORTS-1:0]                grant;
    int                                  rr_sum;
    logic [PORT_W-1:0]                   rr_idx;

    // Request matrix; out-of-range directions match no output and are never granted
    always_comb begin
        cand = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cand[o][i] = req_valid_i[i] && (req_dir_i[i] == PORT_W'(o));
            end
        end
    end

    // Per-output arbitration: locked outputs serve only their owner, free ones go round-robin
    always_comb begin
        win_vld = '0;
        win_idx = '0;
        rr_sum  = 0;
        rr_idx  = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (out_ready_i[o]) begin
                if (lock_vld_q[o]) begin
                    if (cand[o][lock_own_q[o]]) begin
                        win_vld[o] = 1'b1;
                        win_idx[o] = lock_own_q[o];
                    end
                end else begin
                    // Walk from the far end so the closest candidate to rr_ptr is written last
                    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
                        rr_sum = int'(rr_ptr_q[o]) + k;
                        if (rr_sum >= NUM_PORTS) begin
                            rr_sum = rr_sum - NUM_PORTS;
                        end
                        rr_idx = PORT_W'(rr_sum);
                        if (cand[o][rr_idx]) begin
                            win_vld[o] = 1'b1;
                            win_idx[o] = rr_idx;
                        end
                    end
                end
            end
        end
    end

    // Fold per-output winners into per-input grants (each input asks for one output only)
    always_comb begin
        grant = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (win_vld[o]) begin
                grant[win_idx[o]] = 1'b1;
            end
        end
    end

    // Lock and round-robin pointer updates driven by this cycle's winners
    always_comb begin
        lock_vld_d = lock_vld_q;
        lock_own_d = lock_own_q;
        rr_ptr_d   = rr_ptr_q;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (win_vld[o]) begin
                if (!lock_vld_q[o]) begin
                    rr_ptr_d[o] = (win_idx[o] == PORT_W'(NUM_PORTS - 1)) ? '0 : win_idx[o] + 1'b1;
                    if (LOCK_EN && !req_tail_i[win_idx[o]]) begin
                        lock_vld_d[o] = 1'b1;
                        lock_own_d[o] = win_idx[o];
                    end
                end else if (req_tail_i[win_idx[o]]) begin
                    lock_vld_d[o] = 1'b0;
                end
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_vld_q <= '0;
            lock_own_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            lock_vld_q <= lock_vld_d;
            lock_own_q <= lock_own_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    // Combinational outputs are forced quiet while reset is held
    assign grant_o      = rst_ni ? grant   : '0;
    assign xbar_valid_o = rst_ni ? win_vld : '0;
    assign xbar_sel_o   = rst_ni ? win_idx : '0;
    assign out_locked_o = lock_vld_q;

    // A lock owner must keep asking for the output it holds until its tail leaves
    for (genvar go = 0; go < NUM_PORTS; go++) begin : g_owner_chk
        a_owner_dir: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (lock_vld_q[go] && req_valid_i[lock_own_q[go]])
            |-> (req_dir_i[lock_own_q[go]] == PORT_W'(go)));
    end

endmodule
